codec_spi_cfg_seq: RTL
======================

Name: codec_spi_cfg_seq

Overview:
- Sequences the DECA audio codec's SPI register configuration: power-up wait, write a table of (register, value) pairs, read each back and verify.
- Retries mismatching writes, then reports done or error.
- Replaces the fixed, write-only configuration path feeding AUDIO_SCL_SS_n / AUDIO_SCLK_MFP3 / AUDIO_SDA_MOSI / AUDIO_MISO_MFP4, alongside the I2S audio block on the 50 MHz clock.

Parameters:
- NUM_REGS, 8: table entries, must be >= 1.
- CLK_DIV, 25: clk_50MHz cycles per SCLK half-period (1 MHz SCLK).
- PWRUP_CYC, 50000: cycles waited after reset before the first frame (1 ms).
- VERIFY, 1: 1 = readback after each write, 0 = write only.
- MAX_RETRY, 2: extra write attempts after a readback mismatch.

Ports:
- clk_50MHz  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; reruns the table (no power-up wait); ignored while busy
- tbl_idx  out  $clog2(NUM_REGS) (min 1)  current table index
- tbl_addr  in  7  codec register address for tbl_idx; combinational, valid the same cycle
- tbl_data  in  8  value for tbl_idx
- oCS_n  out  1  SPI chip select, active low
- oSCLK  out  1  SPI clock, CPOL=0
- oDIN  out  1  SPI MOSI
- iDOUT  in  1  SPI MISO
- busy  out  1  sequence in progress
- done  out  1  level; whole table written and verified
- error  out  1  level; retries exhausted
- err_idx  out  $clog2(NUM_REGS)  index that failed
- rd_data  out  8  last readback byte

Behaviour:
- Reset values: oCS_n=1, oSCLK=0, oDIN=0, busy=0, done=0, error=0, tbl_idx=0, err_idx=0, rd_data=0, state=PWRUP.
- Reset asserted mid-frame forces these values on the next edge; no partial frame is completed.
- Frame format: 16 bits, MSB first: {addr[6:0], rw, data[7:0]}, where rw=0 is write and rw=1 is read (data field 0).
- Frame timing (t=0 is the cycle oCS_n falls):
  - oDIN = bit15 at t=0, oSCLK=0.
  - Rising edge k (k=0..15) at t=(2k+1)*CLK_DIV; falling edge k at t=(2k+2)*CLK_DIV.
  - oDIN advances to the next bit on each falling edge.
  - iDOUT is sampled on rising edges 8..15 into a shift register (MSB first).
  - oCS_n rises at t=33*CLK_DIV; oDIN returns to 0.
  - Minimum oCS_n high gap between frames: 2*CLK_DIV cycles.
- States:
  - PWRUP: count PWRUP_CYC cycles with busy=1, then go to WR.
  - WR: write frame for tbl_idx, then GAP.
  - GAP: gap, then RD if VERIFY=1 and tbl_addr != SW_RESET_REG (7'h01, self-clearing), else NEXT.
  - RD: read frame; rd_data is updated one cycle after oCS_n rises; then CHECK.
  - CHECK: rd_data==tbl_data goes to NEXT. On mismatch with retry count < MAX_RETRY, increment the count and go to WR. Otherwise go to ERR.
  - NEXT: clear the retry count. If tbl_idx==NUM_REGS-1, set tbl_idx=0 and go to DONE; else increment tbl_idx and go to WR.
  - DONE: busy=0, done=1.
  - ERR: busy=0, error=1, err_idx latched.
  - IDLE: reachable only from DONE/ERR via start.
- start in DONE or ERR:
  - Clears done and error (err_idx keeps its old value until the next error).
  - Sets tbl_idx=0, busy=1 next cycle, and enters WR.
- start while busy: no effect.
- tbl_addr/tbl_data are sampled at frame start and held internally for the whole frame and the compare.

Decomposition:
- Package codec_cfg_pkg: state enum, SW_RESET_REG=7'h01, RW_WRITE/RW_READ constants, frame width 16.
- Sub-module spi_frame_xfer:
  - Inputs: start, 16-bit tx word, CLK_DIV parameter.
  - Outputs: oCS_n/oSCLK/oDIN, 8-bit rx byte, one-cycle xfer_done pulse.
  - Owns the gap timing.
- Top level holds the sequencing FSM, retry counter and power-up counter.

Test Plan:
- Power-up wait: reset released, PWRUP_CYC=100, CLK_DIV=2 -> oCS_n first falls exactly 100 cycles after reset deasserts; busy=1 from cycle 1.
- Write frame: table {7'h00,8'h00},{7'h0B,8'h81}, VERIFY=0 -> second frame shifts 16'h1681 MSB first, 16 rising edges, oCS_n low for 33*CLK_DIV cycles, then done=1, busy=0, tbl_idx=0.
- Verify with a codec model echoing written values (VERIFY=1) -> each write is followed by a read frame 16'h17_00 for addr 0x0B; rd_data=8'h81; done=1.
- Software reset skip: entry {7'h01,8'h01} -> only a write frame, no read frame, for that index.
- Retry exhaustion: model returns 8'h00 for addr 0x0B, MAX_RETRY=2 -> 3 write+read pairs, then error=1, err_idx=1, done=0, no further frames.
- Reset and rerun:
  - Assert reset mid-frame (bit 5) -> next cycle oCS_n=1, oSCLK=0, power-up wait restarts.
  - After done, pulse start -> table rerun with no power-up wait.
  - start pulsed while busy -> ignored.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec SPI configuration sequencer.
// Frame layout is {addr[6:0], rw, data[7:0]}, shifted MSB first.
package codec_cfg_pkg;

   localparam int         FRAME_W      = 16;
   localparam logic [6:0] SW_RESET_REG = 7'h01;
   localparam logic       RW_WRITE     = 1'b0;
   localparam logic       RW_READ      = 1'b1;

   typedef enum logic [3:0] {
      ST_PWRUP,
      ST_WR,
      ST_GAP,
      ST_RD,
      ST_CHECK,
      ST_NEXT,
      ST_DONE,
      ST_ERR,
      ST_IDLE
   } seq_state_e;

   typedef enum logic [1:0] {
      X_IDLE,
      X_SHIFT,
      X_GAP
   } xfer_state_e;

   function automatic logic [FRAME_W-1:0] mk_frame(
      input logic [6:0] addr,
      input logic       rw,
      input logic [7:0] data
   );
      return {addr, rw, data};
   endfunction

endpackage

// File: rtl/spi_frame_xfer.sv
// One 16-bit CPOL=0 SPI frame per start; captures the last 8 MISO bits
// and enforces the chip-select high gap before accepting the next frame.
module spi_frame_xfer
   import codec_cfg_pkg::*;
#(
   parameter int CLK_DIV = 25
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [FRAME_W-1:0] tx_i,
   input  logic               miso_i,
   output logic               cs_n_o,
   output logic               sclk_o,
   output logic               mosi_o,
   output logic [7:0]         rx_o,
   output logic               done_o,
   output logic               ready_o
);

   localparam int CW = $clog2(2 * CLK_DIV);

   xfer_state_e        xst_q, xst_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [5:0]         hp_q, hp_d;
   logic [FRAME_W-1:0] sh_q, sh_d;
   logic [7:0]         rx_q, rx_d;
   logic               cs_n_q, cs_n_d;
   logic               sclk_q, sclk_d;
   logic               done_q, done_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         xst_q  <= X_IDLE;
         cnt_q  <= '0;
         hp_q   <= '0;
         sh_q   <= '0;
         rx_q   <= '0;
         cs_n_q <= 1'b1;
         sclk_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         xst_q  <= xst_d;
         cnt_q  <= cnt_d;
         hp_q   <= hp_d;
         sh_q   <= sh_d;
         rx_q   <= rx_d;
         cs_n_q <= cs_n_d;
         sclk_q <= sclk_d;
         done_q <= done_d;
      end
   end

   // hp_q counts SCLK half-periods; event m=hp_q+1 fires as cnt_q wraps
   always_comb begin
      xst_d  = xst_q;
      cnt_d  = cnt_q;
      hp_d   = hp_q;
      sh_d   = sh_q;
      rx_d   = rx_q;
      cs_n_d = cs_n_q;
      sclk_d = sclk_q;
      done_d = 1'b0;
      unique case (xst_q)
         X_IDLE: begin
            if (start_i) begin
               xst_d  = X_SHIFT;
               cnt_d  = '0;
               hp_d   = '0;
               sh_d   = tx_i;
               cs_n_d = 1'b0;
            end
         end
         X_SHIFT: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d = '0;
               hp_d  = hp_q + 6'd1;
               if (hp_q == 6'd32) begin
                  cs_n_d = 1'b1;
                  sh_d   = '0;
                  done_d = 1'b1;
                  xst_d  = X_GAP;
               end else if (!hp_q[0]) begin
                  sclk_d = 1'b1;
                  if (hp_q >= 6'd16) begin
                     rx_d = {rx_q[6:0], miso_i};
                  end
               end else begin
                  sclk_d = 1'b0;
                  sh_d   = {sh_q[FRAME_W-2:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         X_GAP: begin
            if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
               cnt_d = '0;
               xst_d = X_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: xst_d = X_IDLE;
      endcase
   end

   assign cs_n_o  = cs_n_q;
   assign sclk_o  = sclk_q;
   assign mosi_o  = sh_q[FRAME_W-1];
   assign rx_o    = rx_q;
   assign done_o  = done_q;
   assign ready_o = (xst_q == X_IDLE);

endmodule

// File: rtl/codec_spi_cfg_seq.sv
// Codec register configuration sequencer: power-up wait, write each table
// entry, optionally read it back, retry mismatches, report done or error.
module codec_spi_cfg_seq
   import codec_cfg_pkg::*;
#(
   parameter int  NUM_REGS  = 8,
   parameter int  CLK_DIV   = 25,
   parameter int  PWRUP_CYC = 50000,
   parameter int  VERIFY    = 1,
   parameter int  MAX_RETRY = 2,
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic          clk_50MHz,
   input  logic          reset,
   input  logic          start,
   output logic [IW-1:0] tbl_idx,
   input  logic [6:0]    tbl_addr,
   input  logic [7:0]    tbl_data,
   output logic          oCS_n,
   output logic          oSCLK,
   output logic          oDIN,
   input  logic          iDOUT,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [IW-1:0] err_idx,
   output logic [7:0]    rd_data
);

   localparam int PW  = $clog2(PWRUP_CYC + 1);
   localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   seq_state_e         state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [IW-1:0]      err_idx_q, err_idx_d;
   logic [RTW-1:0]     retry_q, retry_d;
   logic [PW-1:0]      pwr_q, pwr_d;
   logic               issued_q, issued_d;
   logic [6:0]         addr_q, addr_d;
   logic [7:0]         data_q, data_d;
   logic [7:0]         rd_q, rd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   logic               wr_go;
   logic               x_start;
   logic [FRAME_W-1:0] x_tx;
   logic [7:0]         x_rx;
   logic               x_done;
   logic               x_ready;

   spi_frame_xfer #(
      .CLK_DIV (CLK_DIV)
   ) u_xfer (
      .clk_i   (clk_50MHz),
      .rst_i   (reset),
      .start_i (x_start),
      .tx_i    (x_tx),
      .miso_i  (iDOUT),
      .cs_n_o  (oCS_n),
      .sclk_o  (oSCLK),
      .mosi_o  (oDIN),
      .rx_o    (x_rx),
      .done_o  (x_done),
      .ready_o (x_ready)
   );

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state_q   <= ST_PWRUP;
         idx_q     <= '0;
         err_idx_q <= '0;
         retry_q   <= '0;
         pwr_q     <= '0;
         issued_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         rd_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_idx_q <= err_idx_d;
         retry_q   <= retry_d;
         pwr_q     <= pwr_d;
         issued_q  <= issued_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         rd_q      <= rd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      err_idx_d = err_idx_q;
      retry_d   = retry_q;
      pwr_d     = pwr_q;
      issued_d  = issued_q;
      addr_d    = addr_q;
      data_d    = data_q;
      rd_d      = rd_q;
      wr_go     = 1'b0;
      x_start   = 1'b0;
      x_tx      = mk_frame(addr_q, RW_READ, 8'h00);
      unique case (state_q)
         ST_PWRUP: begin
            // launch on the last wait cycle so CS falls exactly PWRUP_CYC in
            if (pwr_q == PW'(PWRUP_CYC - 1)) begin
               wr_go   = 1'b1;
               state_d = ST_WR;
            end else begin
               pwr_d = pwr_q + 1'b1;
            end
         end
         ST_WR: begin
            if (!issued_q) begin
               wr_go = x_ready;
            end else if (x_done) begin
               issued_d = 1'b0;
               state_d  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (x_ready) begin
               state_d = (VERIFY != 0 && addr_q != SW_RESET_REG)
                       ? ST_RD : ST_NEXT;
            end
         end
         ST_RD: begin
            if (!issued_q) begin
               x_start  = x_ready;
               issued_d = x_ready;
            end else if (x_done) begin
               issued_d = 1'b0;
               rd_d     = x_rx;
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (rd_q == data_q) begin
               state_d = ST_NEXT;
            end else if (retry_q != RTW'(MAX_RETRY)) begin
               retry_d = retry_q + 1'b1;
               state_d = ST_WR;
            end else begin
               err_idx_d = idx_q;
               state_d   = ST_ERR;
            end
         end
         ST_NEXT: begin
            retry_d = '0;
            if (idx_q == IW'(NUM_REGS - 1)) begin
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_WR;
            end
         end
         ST_DONE, ST_ERR: begin
            if (start) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            retry_d = '0;
            state_d = ST_WR;
         end
         default: state_d = ST_PWRUP;
      endcase
      if (wr_go) begin
         x_start  = 1'b1;
         x_tx     = mk_frame(tbl_addr, RW_WRITE, tbl_data);
         addr_d   = tbl_addr;
         data_d   = tbl_data;
         issued_d = 1'b1;
      end
      busy_d  = !(state_d inside {ST_DONE, ST_ERR});
      done_d  = (state_d == ST_DONE);
      error_d = (state_d == ST_ERR);
   end

   assign tbl_idx = idx_q;
   assign err_idx = err_idx_q;
   assign rd_data = rd_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule
